// File: rtl/phone_cmd_pkg.sv
// rtl/phone_cmd_pkg.sv - shared constants, command ids and state types for the phone command receiver
package phone_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hAA;
    localparam logic [7:0] CHK_XOR    = 8'h55;
    localparam logic [3:0] ASSIST_MAX = 4'd10;

    typedef enum logic [7:0] {
        CMD_HR_CAP     = 8'h01,
        CMD_MOTOR_MODE = 8'h02,
        CMD_ASSIST     = 8'h03
    } cmd_e;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        GOT_SYNC = 2'd1,
        GOT_CMD  = 2'd2,
        GOT_DATA = 2'd3
    } parser_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic logic [7:0] clamp_u8(input logic [7:0] v,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 oversampling UART receiver with start-glitch rejection and stop-bit check
module uart_rx_core
    import phone_cmd_pkg::*;
#(
    parameter int DIV        = 27,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       frame_err
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

    uart_state_t       state, state_nxt;
    logic              rx_meta, rx_sync, rx_prev;
    logic [DIV_W-1:0]  div_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;

    logic tick, fall, sample;
    logic start_bit, shift_en, stop_ok, stop_bad;

    assign tick   = (div_cnt == DIV_LAST);
    assign fall   = rx_prev & ~rx_sync;
    // START samples half a bit in; every later sample is a full bit after the previous one
    assign sample = tick && (tick_cnt == ((state == START) ? MID_TICK : LAST_TICK));

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (sample) state_nxt = rx_sync ? IDLE : DATA;
            DATA:  if (sample && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:  if (sample) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_bit = (state == IDLE) && fall;
        shift_en  = (state == DATA) && sample;
        stop_ok   = (state == STOP) && sample && rx_sync;
        stop_bad  = (state == STOP) && sample && !rx_sync;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            data_byte  <= '0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= stop_ok;
            frame_err  <= stop_bad;
            if (start_bit) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                if (tick)
                    tick_cnt <= sample ? '0 : tick_cnt + TICK_W'(1);
            end
            if (shift_en) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (stop_ok)
                data_byte <= shift;
        end
    end

endmodule

// File: rtl/phone_cmd_rx.sv
// rtl/phone_cmd_rx.sv - phone link command frame parser driving heart-rate cap, motor mode and assist level
module phone_cmd_rx
    import phone_cmd_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BAUD           = 115200,
    parameter int OVERSAMPLE     = 16,
    parameter int HR_CAP_DEFAULT = 200,
    parameter int HR_CAP_MIN     = 60,
    parameter int HR_CAP_MAX     = 220,
    parameter int TIMEOUT_CYC    = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] heart_cap,
    output logic [1:0] motor_mode,
    output logic [3:0] assist_level,
    output logic       cmd_strobe,
    output logic [7:0] cmd_id,
    output logic       rx_byte_valid,
    output logic [7:0] rx_byte,
    output logic [7:0] frame_err_cnt,
    output logic [7:0] cksum_err_cnt
);

    localparam int DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC);

    logic frame_err;

    uart_rx_core #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (rx_byte_valid),
        .data_byte  (rx_byte),
        .frame_err  (frame_err)
    );

    parser_state_t   state, state_nxt;
    logic [7:0]      cmd_reg, data_reg;
    logic [TO_W-1:0] idle_cnt;
    logic            cmd_known, chk_ok, apply, chk_err, timeout_hit;

    assign cmd_known = (cmd_reg == CMD_HR_CAP) || (cmd_reg == CMD_MOTOR_MODE) ||
                       (cmd_reg == CMD_ASSIST);
    assign chk_ok    = (rx_byte == (cmd_reg ^ data_reg ^ CHK_XOR));

    always_ff @(posedge clk) begin
        if (reset)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_byte_valid) begin
            case (state)
                HUNT:     if (rx_byte == SYNC_BYTE) state_nxt = GOT_SYNC;
                GOT_SYNC: state_nxt = GOT_CMD;
                GOT_CMD:  state_nxt = GOT_DATA;
                default:  state_nxt = HUNT;
            endcase
        end else if (timeout_hit) begin
            state_nxt = HUNT;
        end
    end

    always_comb begin
        apply       = (state == GOT_DATA) && rx_byte_valid && chk_ok && cmd_known;
        chk_err     = (state == GOT_DATA) && rx_byte_valid && !(chk_ok && cmd_known);
        timeout_hit = (state != HUNT) && (idle_cnt == TO_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg       <= '0;
            data_reg      <= '0;
            idle_cnt      <= '0;
            heart_cap     <= 8'(HR_CAP_DEFAULT);
            motor_mode    <= '0;
            assist_level  <= '0;
            cmd_id        <= '0;
            cmd_strobe    <= 1'b0;
            frame_err_cnt <= '0;
            cksum_err_cnt <= '0;
        end else begin
            cmd_strobe <= apply;
            if (rx_byte_valid)
                idle_cnt <= '0;
            else if (idle_cnt != TO_LAST)
                idle_cnt <= idle_cnt + TO_W'(1);
            if (rx_byte_valid && state == GOT_SYNC)
                cmd_reg <= rx_byte;
            if (rx_byte_valid && state == GOT_CMD)
                data_reg <= rx_byte;
            if (apply) begin
                cmd_id <= cmd_reg;
                case (cmd_reg)
                    CMD_HR_CAP:
                        heart_cap <= clamp_u8(data_reg, 8'(HR_CAP_MIN), 8'(HR_CAP_MAX));
                    CMD_MOTOR_MODE:
                        motor_mode <= data_reg[1:0];
                    CMD_ASSIST:
                        assist_level <= (data_reg > 8'(ASSIST_MAX)) ? ASSIST_MAX : data_reg[3:0];
                    default: ;
                endcase
            end
            if (chk_err && cksum_err_cnt != 8'hFF)
                cksum_err_cnt <= cksum_err_cnt + 8'd1;
            if (frame_err && frame_err_cnt != 8'hFF)
                frame_err_cnt <= frame_err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_phone_cmd_rx.sv
// tb/tb_phone_cmd_rx.sv - directed self-checking bench for phone_cmd_rx at a scaled-up line rate
module tb_phone_cmd_rx;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] heart_cap;
    logic [1:0] motor_mode;
    logic [3:0] assist_level;
    logic       cmd_strobe;
    logic [7:0] cmd_id;
    logic       rx_byte_valid;
    logic [7:0] rx_byte;
    logic [7:0] frame_err_cnt;
    logic [7:0] cksum_err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc = 0, strobe_cnt = 0, valid_cnt = 0, last_valid_cyc = 0, strobe_gap = -1;
    int s0, v0;

    phone_cmd_rx #(
        .CLK_HZ         (50_000_000),
        .BAUD           (781_250),
        .OVERSAMPLE     (16),
        .HR_CAP_DEFAULT (200),
        .HR_CAP_MIN     (60),
        .HR_CAP_MAX     (220),
        .TIMEOUT_CYC    (5000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .heart_cap     (heart_cap),
        .motor_mode    (motor_mode),
        .assist_level  (assist_level),
        .cmd_strobe    (cmd_strobe),
        .cmd_id        (cmd_id),
        .rx_byte_valid (rx_byte_valid),
        .rx_byte       (rx_byte),
        .frame_err_cnt (frame_err_cnt),
        .cksum_err_cnt (cksum_err_cnt)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_byte_valid) begin
            valid_cnt = valid_cnt + 1;
            last_valid_cyc = cyc;
        end
        if (cmd_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_gap = cyc - last_valid_cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hAA, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d, 1'b1);
        send_byte(k, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_heart_cap", 32'(heart_cap), 32'd200);
        check("rst_motor_mode", 32'(motor_mode), 32'd0);
        check("rst_assist", 32'(assist_level), 32'd0);
        check("rst_cmd_id", 32'(cmd_id), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);
        check("rst_strobe", 32'(cmd_strobe), 32'd0);
        check("rst_valid", 32'(rx_byte_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err_cnt), 32'd0);
        check("rst_cksum_err", 32'(cksum_err_cnt), 32'd0);

        send_frame(8'h01, 8'hB4, 8'hE0);
        check("hr180_heart_cap", 32'(heart_cap), 32'd180);
        check("hr180_cmd_id", 32'(cmd_id), 32'h01);
        check("hr180_strobes", 32'(strobe_cnt), 32'd1);
        check("hr180_strobe_gap", 32'(strobe_gap), 32'd1);
        check("hr180_valid_cnt", 32'(valid_cnt), 32'd4);
        check("hr180_rx_byte", 32'(rx_byte), 32'hE0);

        send_frame(8'h01, 8'h28, 8'h7C);
        check("hr_low_clamp", 32'(heart_cap), 32'd60);
        send_frame(8'h01, 8'hF0, 8'hA4);
        check("hr_high_clamp", 32'(heart_cap), 32'd220);
        send_frame(8'h03, 8'h0F, 8'h59);
        check("assist_clamp", 32'(assist_level), 32'd10);
        check("assist_cmd_id", 32'(cmd_id), 32'h03);
        check("assist_strobes", 32'(strobe_cnt), 32'd4);

        s0 = strobe_cnt;
        send_frame(8'h02, 8'h03, 8'h00);
        check("badchk_motor", 32'(motor_mode), 32'd0);
        check("badchk_cksum_err", 32'(cksum_err_cnt), 32'd1);
        check("badchk_no_strobe", 32'(strobe_cnt), 32'(s0));
        send_frame(8'h02, 8'h03, 8'h54);
        check("motor_mode3", 32'(motor_mode), 32'd3);
        check("motor_cksum_err", 32'(cksum_err_cnt), 32'd1);
        check("motor_heart_kept", 32'(heart_cap), 32'd220);

        v0 = valid_cnt;
        rx = 1'b0;
        repeat (BIT / 4) @(negedge clk);
        rx = 1'b1;
        repeat (BIT * 12) @(negedge clk);
        check("glitch_no_byte", 32'(valid_cnt), 32'(v0));
        check("glitch_no_ferr", 32'(frame_err_cnt), 32'd0);
        send_byte(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr_count", 32'(frame_err_cnt), 32'd1);
        check("ferr_no_byte", 32'(valid_cnt), 32'(v0));
        check("ferr_rx_byte_held", 32'(rx_byte), 32'h54);

        s0 = strobe_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (6000) @(negedge clk);
        send_byte(8'hB4, 1'b1);
        send_byte(8'hE0, 1'b1);
        repeat (20) @(negedge clk);
        check("timeout_heart_kept", 32'(heart_cap), 32'd220);
        check("timeout_no_cksum_err", 32'(cksum_err_cnt), 32'd1);
        check("timeout_no_strobe", 32'(strobe_cnt), 32'(s0));
        send_frame(8'h01, 8'hB4, 8'hE0);
        check("post_timeout_apply", 32'(heart_cap), 32'd180);

        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (BIT) @(negedge clk);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        repeat (BIT * 12) @(negedge clk);
        check("midrst_heart_cap", 32'(heart_cap), 32'd200);
        check("midrst_cmd_id", 32'(cmd_id), 32'd0);
        check("midrst_motor", 32'(motor_mode), 32'd0);
        check("midrst_cksum_err", 32'(cksum_err_cnt), 32'd0);
        check("midrst_frame_err", 32'(frame_err_cnt), 32'd0);
        check("midrst_rx_byte", 32'(rx_byte), 32'd0);
        s0 = strobe_cnt;
        send_frame(8'h01, 8'h96, 8'hC2);
        check("after_rst_heart_cap", 32'(heart_cap), 32'd150);
        check("after_rst_cmd_id", 32'(cmd_id), 32'h01);
        check("after_rst_strobe", 32'(strobe_cnt), 32'(s0 + 1));
        check("after_rst_gap", 32'(strobe_gap), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
